// File: rtl/imm_extend_unit.sv
// Immediate extender: zero/sign extension with optional left shift and overflow detect,
// behind a valid/ready interface with an output register plus a one-entry skid register.
module imm_extend_unit #(
  parameter int unsigned IN_W    = 2,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    immediate,
  input  logic [1:0]         mode,
  input  logic [SHIFT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   extended,
  output logic               overflow,
  output logic [CNT_W-1:0]   xfer_count
);

  localparam int unsigned FullW = OUT_W + (2 ** SHIFT_W) - 1;

  logic               w_signed;
  logic               w_sign;
  logic [FullW-1:0]   w_ext;
  logic [SHIFT_W-1:0] w_shamt;
  logic [FullW-1:0]   w_full;
  logic               w_res_sign;
  logic [FullW-1:0]   w_reext;
  logic               w_ovf;
  logic [OUT_W:0]     w_new;

  assign w_signed   = (mode == 2'b01) || (mode == 2'b10);
  assign w_sign     = w_signed & immediate[IN_W-1];
  assign w_ext      = {{(FullW - IN_W){w_sign}}, immediate};
  assign w_shamt    = mode[1] ? shamt : '0;
  assign w_full     = w_ext << w_shamt;
  // Overflow: truncated result, re-extended with the same signedness, no longer matches.
  assign w_res_sign = w_signed & w_full[OUT_W-1];
  assign w_reext    = {{(FullW - OUT_W){w_res_sign}}, w_full[OUT_W-1:0]};
  assign w_ovf      = mode[1] & (w_full != w_reext);
  assign w_new      = {w_ovf, w_full[OUT_W-1:0]};

  logic             r_or_valid, w_or_valid_d;
  logic [OUT_W:0]   r_or_data,  w_or_data_d;
  logic             r_sk_valid, w_sk_valid_d;
  logic [OUT_W:0]   r_sk_data,  w_sk_data_d;
  logic [CNT_W-1:0] r_xfer,     w_xfer_d;
  logic             w_accept;
  logic             w_drain;

  assign in_ready = ~r_sk_valid;
  assign w_accept = in_valid & ~r_sk_valid;
  assign w_drain  = r_or_valid & out_ready;

  always_comb begin
    w_or_valid_d = r_or_valid;
    w_or_data_d  = r_or_data;
    w_sk_valid_d = r_sk_valid;
    w_sk_data_d  = r_sk_data;
    w_xfer_d     = r_xfer;
    if (w_drain) begin
      w_xfer_d = r_xfer + 1'b1;
      if (r_sk_valid) begin
        // Skid full means no accept this cycle; promote it.
        w_or_data_d  = r_sk_data;
        w_sk_valid_d = 1'b0;
      end else if (w_accept) begin
        w_or_data_d = w_new;
      end else begin
        w_or_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (!r_or_valid) begin
        w_or_valid_d = 1'b1;
        w_or_data_d  = w_new;
      end else begin
        w_sk_valid_d = 1'b1;
        w_sk_data_d  = w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
      r_xfer     <= '0;
    end else begin
      r_or_valid <= w_or_valid_d;
      r_or_data  <= w_or_data_d;
      r_sk_valid <= w_sk_valid_d;
      r_sk_data  <= w_sk_data_d;
      r_xfer     <= w_xfer_d;
    end
  end

  assign out_valid  = r_or_valid;
  assign extended   = r_or_data[OUT_W-1:0];
  assign overflow   = r_or_data[OUT_W];
  assign xfer_count = r_xfer;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed, table-driven bench for imm_extend_unit at IN_W=2, OUT_W=8, SHIFT_W=3.
module tb_imm_extend_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] immediate;
  logic [1:0] mode;
  logic [2:0] shamt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] extended;
  logic       overflow;
  logic [15:0] xfer_count;

  imm_extend_unit #(.IN_W(2), .OUT_W(8), .SHIFT_W(3), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .immediate  (immediate),
    .mode       (mode),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .extended   (extended),
    .overflow   (overflow),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] imm;
    logic [1:0] md;
    logic [2:0] sh;
    logic [7:0] exp_ext;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[13];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int k);
    immediate = vecs[k].imm;
    mode      = vecs[k].md;
    shamt     = vecs[k].sh;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 2'b01, 3'd0, 8'hFE, 1'b0};
    vecs[1]  = '{2'b10, 2'b00, 3'd0, 8'h02, 1'b0};
    vecs[2]  = '{2'b10, 2'b10, 3'd3, 8'hF0, 1'b0};
    vecs[3]  = '{2'b10, 2'b10, 3'd7, 8'h00, 1'b1};
    vecs[4]  = '{2'b01, 2'b10, 3'd7, 8'h80, 1'b1};
    vecs[5]  = '{2'b11, 2'b11, 3'd7, 8'h80, 1'b1};
    vecs[6]  = '{2'b11, 2'b00, 3'd5, 8'h03, 1'b0};
    vecs[7]  = '{2'b11, 2'b01, 3'd5, 8'hFF, 1'b0};
    vecs[8]  = '{2'b01, 2'b11, 3'd6, 8'h40, 1'b0};
    vecs[9]  = '{2'b11, 2'b10, 3'd6, 8'hC0, 1'b0};
    vecs[10] = '{2'b01, 2'b10, 3'd6, 8'h40, 1'b0};
    vecs[11] = '{2'b11, 2'b11, 3'd6, 8'hC0, 1'b0};
    vecs[12] = '{2'b01, 2'b10, 3'd0, 8'h01, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    immediate = '0; mode = '0; shamt = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_extended", extended, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_xfer", xfer_count, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // Single transactions, one cycle latency each.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(i); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_ext", i), extended, vecs[i].exp_ext);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
    end
    exp_cnt = 13;
    chk("xfer_after_table", xfer_count, exp_cnt);

    // Back-pressure: OR then SK fill, third input waits.
    out_ready = 1'b0;
    drive(0); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_ext", extended, 8'hFE);
    chk("bp_ready_after_1", in_ready, 1);
    drive(1);
    @(posedge clk); #1;
    chk("bp_ready_after_2", in_ready, 0);
    chk("bp_a_hold", extended, 8'hFE);
    drive(11);
    @(posedge clk); #1;
    chk("bp_still_full", in_ready, 0);
    chk("bp_a_hold2", extended, 8'hFE);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b_ext", extended, 8'h02);
    chk("bp_ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_c_ext", extended, 8'hC0);
    chk("bp_c_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);
    exp_cnt += 3;
    chk("bp_xfer", xfer_count, exp_cnt);

    // Streaming: one result per cycle, in_ready never drops.
    for (int i = 0; i < 100; i++) begin
      drive(i % 13); in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("st%0d_ext", i), extended, vecs[i % 13].exp_ext);
      chk($sformatf("st%0d_ovf", i), overflow, vecs[i % 13].exp_ovf);
      chk($sformatf("st%0d_valid", i), out_valid, 1);
      chk($sformatf("st%0d_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_cnt += 100;
    chk("st_xfer", xfer_count, exp_cnt);

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    drive(4); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_xfer", xfer_count, 0);
    chk("ar_extended", extended, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    chk("ar_in_ready", in_ready, 1);
    chk("ar_still_empty", out_valid, 0);
    out_ready = 1'b1;
    drive(2); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_new_ext", extended, 8'hF0);
    chk("ar_new_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("ar_new_xfer", xfer_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
